accel_lock_arbiter: RTL

ACCEL_LOCK_ARBITER -- requirements
Module: accel_lock_arbiter

---
 rtl/accel_lock_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/accel_lock_arbiter.sv
// Mutual-exclusion lock in front of one shared accelerator: round-robin grant,
// idle watchdog with forced release, and a one-cycle cooldown between owners.
//
// state    | meaning
// FREE     | no owner; acquire requests are arbitrated round-robin
// HELD     | owner_q holds the accelerator; watchdog running
// COOLDOWN | one dead cycle after release/timeout; requests ignored
module accel_lock_arbiter #(
    parameter int unsigned N_CLIENTS = 2,
    parameter logic [31:0] LOCK_ADDR = 32'h54,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_in       [N_CLIENTS],
    input  logic        wr_en_in      [N_CLIENTS],
    input  logic        select_in     [N_CLIENTS],
    input  logic [31:0] data_in       [N_CLIENTS],
    input  logic [31:0] data_accel_in,
    output logic [31:0] addr_o,
    output logic        wr_en_o,
    output logic        accel_select_o,
    output logic [31:0] data_out      [N_CLIENTS],
    output logic [31:0] lock_owner_o,
    output logic        timeout_evt_o
);

    typedef enum logic [1:0] {FREE, HELD, COOLDOWN} state_t;

    localparam logic [31:0] NC      = 32'(N_CLIENTS);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t      state_q;
    logic [31:0] owner_q;
    logic [31:0] last_owner_q;
    logic [31:0] wdog_q;
    logic        timeout_evt_q;

    logic [N_CLIENTS-1:0] acq;
    logic [N_CLIENTS-1:0] rel;
    logic                 own_sel;
    logic                 own_wr;
    logic                 own_rel;
    logic [31:0]          own_addr;
    logic                 gnt_found;
    logic [31:0]          gnt_idx;
    logic [31:0]          cand;

    always_comb begin
        acq      = '0;
        rel      = '0;
        own_sel  = 1'b0;
        own_wr   = 1'b0;
        own_rel  = 1'b0;
        own_addr = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            acq[i] = select_in[i] && wr_en_in[i] && (addr_in[i] == LOCK_ADDR)
                     && (data_in[i] == 32'd1);
            rel[i] = select_in[i] && wr_en_in[i] && (addr_in[i] == LOCK_ADDR)
                     && (data_in[i] == 32'd0);
            if (owner_q == 32'(i)) begin
                own_sel  = select_in[i];
                own_wr   = wr_en_in[i];
                own_rel  = rel[i];
                own_addr = addr_in[i];
            end
        end
    end

    // Search starts one past the previous owner; candidate never exceeds 2N-1,
    // so a single wrap subtraction keeps it in range.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = NC;
        cand      = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            cand = last_owner_q + 32'd1 + 32'(k);
            if (cand >= NC) cand = cand - NC;
            for (int j = 0; j < N_CLIENTS; j++) begin
                if (!gnt_found && cand == 32'(j) && acq[j]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FREE;
            owner_q       <= NC;
            last_owner_q  <= NC - 32'd1;
            wdog_q        <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            timeout_evt_q <= 1'b0;
            case (state_q)
                FREE: begin
                    if (gnt_found) begin
                        state_q      <= HELD;
                        owner_q      <= gnt_idx;
                        last_owner_q <= gnt_idx;
                        wdog_q       <= '0;
                    end
                end
                HELD: begin
                    if (own_rel) begin
                        state_q <= COOLDOWN;
                        owner_q <= NC;
                        wdog_q  <= '0;
                    end else if (own_sel) begin
                        wdog_q <= '0;
                    end else if (wdog_q >= TO_LAST) begin
                        state_q       <= COOLDOWN;
                        owner_q       <= NC;
                        wdog_q        <= '0;
                        timeout_evt_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 32'd1;
                    end
                end
                COOLDOWN: state_q <= FREE;
                default: begin
                    state_q <= FREE;
                    owner_q <= NC;
                end
            endcase
        end
    end

    assign lock_owner_o  = owner_q;
    assign timeout_evt_o = timeout_evt_q;

    // Lock-register traffic from the owner never reaches the accelerator.
    always_comb begin
        addr_o         = '0;
        wr_en_o        = 1'b0;
        accel_select_o = 1'b0;
        if (state_q == HELD && own_addr != LOCK_ADDR) begin
            addr_o         = own_addr;
            wr_en_o        = own_wr;
            accel_select_o = own_sel;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (addr_in[i] == LOCK_ADDR)
                data_out[i] = owner_q;
            else if (state_q == HELD && owner_q == 32'(i))
                data_out[i] = data_accel_in;
            else
                data_out[i] = '0;
        end
    end

endmodule
